// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - paced sequential SPRAM reader feeding a valid/ready word stream through a small FIFO
// Optional feature macro: RAM_STREAM_READER_CHECKSUM_EN (adds a 16-bit wrapping checksum output)
module ram_stream_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  output logic [31:0]      mem_addr,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  input  logic [15:0]      mem_data_read,
  input  logic             mem_data_read_valid,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef RAM_STREAM_READER_CHECKSUM_EN
  ,
  output logic [15:0]      checksum
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic             r_stall;
  logic [31:0]      r_addr_q;
  logic [LEN_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;
  logic             r_rd_en;

  logic [15:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [CNT_W-1:0] w_count_next;
  logic             w_will_be_full;
  logic             w_unused_base_bit0;

  // The byte-address LSB is forced to zero, so that input bit never reaches logic.
  assign w_unused_base_bit0 = base_addr[0];

  // Only a response to our own outstanding read (WAIT, not stalled) is captured.
  assign w_empty        = (r_count == '0);
  assign w_push         = (r_state == S_WAIT) && !r_stall && mem_data_read_valid;
  assign w_pop          = !w_empty && out_ready;
  assign w_count_next   = r_count + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop};
  assign w_will_be_full = (w_count_next == CNT_W'(FIFO_DEPTH));

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_addr  = r_addr_q;
  assign mem_rd_en = r_rd_en;
  assign mem_wr_en = 1'b0;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 16'h0000 : r_mem[r_rd_ptr];

  // Read-sequencing FSM; rd_en is registered together with entry into ISSUE so it is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_stall     <= 1'b0;
      r_addr_q    <= 32'h0000_0000;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr_q    <= {base_addr[31:1], 1'b0};
            r_remaining <= num_words;
            r_busy      <= 1'b1;
            if (num_words != '0) begin
              r_state <= S_ISSUE;
              r_rd_en <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_stall <= 1'b0;
        end
        S_WAIT: begin
          if (r_stall) begin
            // FIFO was full after the last push; any pop frees the entry the next read needs.
            if (w_pop) begin
              r_stall <= 1'b0;
              r_state <= S_ISSUE;
              r_rd_en <= 1'b1;
            end
          end else if (mem_data_read_valid) begin
            r_addr_q    <= r_addr_q + 32'd2;
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_state <= S_DRAIN;
            end else if (!w_will_be_full) begin
              r_state <= S_ISSUE;
              r_rd_en <= 1'b1;
            end else begin
              r_stall <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop on a full FIFO leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= mem_data_read;
  end

`ifdef RAM_STREAM_READER_CHECKSUM_EN
  logic [15:0] r_checksum;

  assign checksum = r_checksum;

  // Running wrapping sum of every captured word, restarted by each accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= 16'h0000;
    end else if ((r_state == S_IDLE) && start) begin
      r_checksum <= 16'h0000;
    end else if (w_push) begin
      r_checksum <= r_checksum + mem_data_read;
    end
  end
`endif

endmodule
